id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 20 ++
 rtl/id_ex_stage_if.sv | 51 +++++
 rtl/id_ex_stage_fwd_mux.sv | 43 ++++
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared widths and encodings for the ID/EX pipeline stage
package id_ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    LOG_AND = 2'd0,
    LOG_OR  = 2'd1,
    LOG_NOR = 2'd2,
    LOG_XOR = 2'd3
  } log_op_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side inputs, bypass sources and EX-side outputs of the ID/EX stage
interface id_ex_stage_if #(
  parameter int DATA_W = id_ex_stage_pkg::DATA_W,
  parameter int REG_W  = id_ex_stage_pkg::REG_W
);

  logic              i_valid;
  logic              i_stall;
  logic              i_flush;
  logic [REG_W-1:0]  i_rs_addr;
  logic [REG_W-1:0]  i_rt_addr;
  logic [DATA_W-1:0] i_rs_data;
  logic [DATA_W-1:0] i_rt_data;
  logic [DATA_W-1:0] i_imm;
  logic              i_alusrc;
  logic [1:0]        i_logcontrl;
  logic [REG_W-1:0]  i_rd_addr;
  logic              i_regwrite;

  logic              i_exmem_regwrite;
  logic [REG_W-1:0]  i_exmem_rd;
  logic [DATA_W-1:0] i_exmem_data;
  logic              i_memwb_regwrite;
  logic [REG_W-1:0]  i_memwb_rd;
  logic [DATA_W-1:0] i_memwb_data;

  logic              o_valid;
  logic [DATA_W-1:0] o_A;
  logic [DATA_W-1:0] o_B;
  logic [DATA_W-1:0] o_rt_fwd;
  logic [1:0]        o_logcontrl;
  logic [REG_W-1:0]  o_rd_addr;
  logic              o_regwrite;

  modport master (
    output i_valid, i_stall, i_flush, i_rs_addr, i_rt_addr, i_rs_data, i_rt_data,
           i_imm, i_alusrc, i_logcontrl, i_rd_addr, i_regwrite,
           i_exmem_regwrite, i_exmem_rd, i_exmem_data,
           i_memwb_regwrite, i_memwb_rd, i_memwb_data,
    input  o_valid, o_A, o_B, o_rt_fwd, o_logcontrl, o_rd_addr, o_regwrite
  );

  modport slave (
    input  i_valid, i_stall, i_flush, i_rs_addr, i_rt_addr, i_rs_data, i_rt_data,
           i_imm, i_alusrc, i_logcontrl, i_rd_addr, i_regwrite,
           i_exmem_regwrite, i_exmem_rd, i_exmem_data,
           i_memwb_regwrite, i_memwb_rd, i_memwb_data,
    output o_valid, o_A, o_B, o_rt_fwd, o_logcontrl, o_rd_addr, o_regwrite
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// rtl/id_ex_stage_fwd_mux.sv - operand bypass select: EX/MEM over MEM/WB over register file
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DW = id_ex_stage_pkg::DATA_W,
  parameter int RW = id_ex_stage_pkg::REG_W
) (
  input  logic [RW-1:0] addr,
  input  logic [DW-1:0] rf_data,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_data,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic [DW-1:0] data
);

  fwd_sel_e sel;

  // Pick the youngest in-flight writer of this register; register 0 is never bypassed
  always_comb begin
    sel = FWD_RF;
    if (addr != '0) begin
      if (exmem_regwrite && (exmem_rd == addr)) begin
        sel = FWD_EXMEM;
      end else if (memwb_regwrite && (memwb_rd == addr)) begin
        sel = FWD_MEMWB;
      end
    end
  end

  // Steer the selected source onto the operand
  always_comb begin
    data = rf_data;
    case (sel)
      FWD_EXMEM: data = exmem_data;
      FWD_MEMWB: data = memwb_data;
      default:   data = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with stall, flush and operand forwarding
module id_ex_stage #(
  parameter int DATA_W = id_ex_stage_pkg::DATA_W,
  parameter int REG_W  = id_ex_stage_pkg::REG_W
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  id_ex_stage_if.slave  bus
);

  import id_ex_stage_pkg::*;

  logic              valid_q,   valid_d;
  logic [REG_W-1:0]  rs_addr_q, rs_addr_d;
  logic [REG_W-1:0]  rt_addr_q, rt_addr_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic              alusrc_q,  alusrc_d;
  logic [1:0]        log_q,     log_d;
  logic [REG_W-1:0]  rd_q,      rd_d;
  logic              rw_q,      rw_d;

  logic              retire_rs;
  logic              retire_rt;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  assign retire_rs = bus.i_memwb_regwrite && (bus.i_memwb_rd == rs_addr_q) && (rs_addr_q != '0);
  assign retire_rt = bus.i_memwb_regwrite && (bus.i_memwb_rd == rt_addr_q) && (rt_addr_q != '0);

  // Next stage contents: flush inserts a bubble, stall holds but captures retiring writes
  always_comb begin
    valid_d   = valid_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    alusrc_d  = alusrc_q;
    log_d     = log_q;
    rd_d      = rd_q;
    rw_d      = rw_q;
    if (bus.i_flush) begin
      valid_d   = 1'b0;
      rs_addr_d = '0;
      rt_addr_d = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      alusrc_d  = 1'b0;
      log_d     = LOG_AND;
      rd_d      = '0;
      rw_d      = 1'b0;
    end else if (!bus.i_stall) begin
      valid_d   = bus.i_valid;
      rs_addr_d = bus.i_rs_addr;
      rt_addr_d = bus.i_rt_addr;
      rs_data_d = bus.i_rs_data;
      rt_data_d = bus.i_rt_data;
      imm_d     = bus.i_imm;
      alusrc_d  = bus.i_alusrc;
      log_d     = bus.i_logcontrl;
      rd_d      = bus.i_rd_addr;
      rw_d      = bus.i_regwrite;
    end else if (valid_q) begin
      if (retire_rs) rs_data_d = bus.i_memwb_data;
      if (retire_rt) rt_data_d = bus.i_memwb_data;
    end
  end

  // Stage register; reset clears straight to bubble without waiting for the clock
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q   <= 1'b0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      alusrc_q  <= 1'b0;
      log_q     <= LOG_AND;
      rd_q      <= '0;
      rw_q      <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      alusrc_q  <= alusrc_d;
      log_q     <= log_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
    end
  end

  fwd_mux #(.DW(DATA_W), .RW(REG_W)) u_fwd_rs (
    .addr           (rs_addr_q),
    .rf_data        (rs_data_q),
    .exmem_regwrite (bus.i_exmem_regwrite),
    .exmem_rd       (bus.i_exmem_rd),
    .exmem_data     (bus.i_exmem_data),
    .memwb_regwrite (bus.i_memwb_regwrite),
    .memwb_rd       (bus.i_memwb_rd),
    .memwb_data     (bus.i_memwb_data),
    .data           (fwd_rs)
  );

  fwd_mux #(.DW(DATA_W), .RW(REG_W)) u_fwd_rt (
    .addr           (rt_addr_q),
    .rf_data        (rt_data_q),
    .exmem_regwrite (bus.i_exmem_regwrite),
    .exmem_rd       (bus.i_exmem_rd),
    .exmem_data     (bus.i_exmem_data),
    .memwb_regwrite (bus.i_memwb_regwrite),
    .memwb_rd       (bus.i_memwb_rd),
    .memwb_data     (bus.i_memwb_data),
    .data           (fwd_rt)
  );

  assign bus.o_valid     = valid_q;
  assign bus.o_A         = fwd_rs;
  assign bus.o_rt_fwd    = fwd_rt;
  assign bus.o_B         = alusrc_q ? imm_q : fwd_rt;
  assign bus.o_logcontrl = log_q;
  assign bus.o_rd_addr   = rd_q;
  assign bus.o_regwrite  = rw_q & valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the EX slot currently holds
  logic        m_valid;
  logic [4:0]  m_rs_addr, m_rt_addr, m_rd;
  logic [31:0] m_rs_data, m_rt_data, m_imm;
  logic        m_alusrc, m_rw;
  logic [1:0]  m_log;

  task automatic model_bubble();
    m_valid = 0; m_rs_addr = 0; m_rt_addr = 0; m_rd = 0;
    m_rs_data = 0; m_rt_data = 0; m_imm = 0; m_alusrc = 0; m_rw = 0; m_log = 0;
  endtask

  task automatic model_clock();
    if (bus.i_flush) begin
      model_bubble();
    end else if (!bus.i_stall) begin
      m_valid = bus.i_valid; m_rs_addr = bus.i_rs_addr; m_rt_addr = bus.i_rt_addr;
      m_rs_data = bus.i_rs_data; m_rt_data = bus.i_rt_data; m_imm = bus.i_imm;
      m_alusrc = bus.i_alusrc; m_log = bus.i_logcontrl; m_rd = bus.i_rd_addr; m_rw = bus.i_regwrite;
    end else if (m_valid) begin
      if (bus.i_memwb_regwrite && bus.i_memwb_rd == m_rs_addr && m_rs_addr != 0) m_rs_data = bus.i_memwb_data;
      if (bus.i_memwb_regwrite && bus.i_memwb_rd == m_rt_addr && m_rt_addr != 0) m_rt_data = bus.i_memwb_data;
    end
  endtask

  function automatic logic [31:0] exp_fwd(input logic [4:0] a, input logic [31:0] d);
    if (a == 0) return d;
    if (bus.i_exmem_regwrite && bus.i_exmem_rd == a) return bus.i_exmem_data;
    if (bus.i_memwb_regwrite && bus.i_memwb_rd == a) return bus.i_memwb_data;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                        input logic [4:0] rt, input logic [31:0] rtd, input logic [31:0] imm,
                        input logic alusrc, input logic [1:0] lg, input logic [4:0] rd, input logic rw);
    bus.i_valid = v; bus.i_rs_addr = rs; bus.i_rs_data = rsd; bus.i_rt_addr = rt; bus.i_rt_data = rtd;
    bus.i_imm = imm; bus.i_alusrc = alusrc; bus.i_logcontrl = lg; bus.i_rd_addr = rd; bus.i_regwrite = rw;
  endtask

  task automatic clear_bypass();
    bus.i_exmem_regwrite = 0; bus.i_exmem_rd = 0; bus.i_exmem_data = 0;
    bus.i_memwb_regwrite = 0; bus.i_memwb_rd = 0; bus.i_memwb_data = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    bus.i_stall = 0; bus.i_flush = 0;
    set_id(1, 5'd3, 32'h1111, 5'd4, 32'h2222, 32'h3333, 0, 2'd1, 5'd7, 1);
    clear_bypass();
    model_bubble();
    #12;
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
    n_vec++; if (bus.o_A !== 32'h0) begin n_err++; $display("FAIL reset_A got %h want 0", bus.o_A); end
    n_vec++; if (bus.o_B !== 32'h0) begin n_err++; $display("FAIL reset_B got %h want 0", bus.o_B); end
    n_vec++; if (bus.o_regwrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite got %b want 0", bus.o_regwrite); end
    n_vec++; if (bus.o_rd_addr !== 5'd0) begin n_err++; $display("FAIL reset_rd got %h want 0", bus.o_rd_addr); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic();
    bus.i_stall = 0; bus.i_flush = 0;
    clear_bypass();
    set_id(1, 5'd3, 32'h0000_00F0, 5'd4, 32'h0000_000F, 32'h0, 0, 2'd2, 5'd9, 1);
    step();
    n_vec++; if (bus.o_A !== 32'hF0) begin n_err++; $display("FAIL basic_A got %h want 000000f0", bus.o_A); end
    n_vec++; if (bus.o_B !== 32'h0F) begin n_err++; $display("FAIL basic_B got %h want 0000000f", bus.o_B); end
    n_vec++; if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b want 1", bus.o_valid); end
    n_vec++; if (bus.o_regwrite !== 1'b1) begin n_err++; $display("FAIL basic_regwrite got %b want 1", bus.o_regwrite); end
    n_vec++; if (bus.o_rd_addr !== 5'd9) begin n_err++; $display("FAIL basic_rd got %h want 09", bus.o_rd_addr); end
    n_vec++; if (bus.o_logcontrl !== 2'd2) begin n_err++; $display("FAIL basic_log got %h want 2", bus.o_logcontrl); end
    // Immediate operand
    set_id(1, 5'd3, 32'h10, 5'd4, 32'h20, 32'hFFFF_FFF0, 1, 2'd3, 5'd1, 0);
    step();
    n_vec++; if (bus.o_B !== 32'hFFFF_FFF0) begin n_err++; $display("FAIL imm_B got %h want fffffff0", bus.o_B); end
    n_vec++; if (bus.o_rt_fwd !== 32'h20) begin n_err++; $display("FAIL imm_rtfwd got %h want 00000020", bus.o_rt_fwd); end
    n_vec++; if (bus.o_regwrite !== 1'b0) begin n_err++; $display("FAIL imm_regwrite got %b want 0", bus.o_regwrite); end
  endtask

  task automatic test_exmem_priority();
    bus.i_stall = 0; bus.i_flush = 0;
    clear_bypass();
    set_id(1, 5'd5, 32'h0000_0011, 5'd6, 32'h0000_0022, 32'h0, 0, 2'd0, 5'd2, 1);
    step();
    bus.i_exmem_regwrite = 1; bus.i_exmem_rd = 5'd5; bus.i_exmem_data = 32'hAAAA_0000;
    bus.i_memwb_regwrite = 1; bus.i_memwb_rd = 5'd5; bus.i_memwb_data = 32'h5555_0000;
    #1;
    n_vec++; if (bus.o_A !== 32'hAAAA_0000) begin n_err++; $display("FAIL prio_A got %h want aaaa0000", bus.o_A); end
    bus.i_exmem_regwrite = 0;
    #1;
    n_vec++; if (bus.o_A !== 32'h5555_0000) begin n_err++; $display("FAIL memwb_A got %h want 55550000", bus.o_A); end
    bus.i_memwb_rd = 5'd6;
    #1;
    n_vec++; if (bus.o_A !== 32'h11) begin n_err++; $display("FAIL nofwd_A got %h want 00000011", bus.o_A); end
    n_vec++; if (bus.o_B !== 32'h5555_0000) begin n_err++; $display("FAIL memwb_B got %h want 55550000", bus.o_B); end
    clear_bypass();
  endtask

  task automatic test_reg0();
    bus.i_stall = 0; bus.i_flush = 0;
    clear_bypass();
    set_id(1, 5'd0, 32'h0, 5'd0, 32'h77, 32'h0, 0, 2'd1, 5'd3, 1);
    step();
    bus.i_exmem_regwrite = 1; bus.i_exmem_rd = 5'd0; bus.i_exmem_data = 32'hFFFF_FFFF;
    bus.i_memwb_regwrite = 1; bus.i_memwb_rd = 5'd0; bus.i_memwb_data = 32'hEEEE_EEEE;
    #1;
    n_vec++; if (bus.o_A !== 32'h0) begin n_err++; $display("FAIL reg0_A got %h want 00000000", bus.o_A); end
    n_vec++; if (bus.o_B !== 32'h77) begin n_err++; $display("FAIL reg0_B got %h want 00000077", bus.o_B); end
    clear_bypass();
  endtask

  task automatic test_stall_retire();
    bus.i_stall = 0; bus.i_flush = 0;
    clear_bypass();
    set_id(1, 5'd2, 32'h2, 5'd7, 32'hDEAD_BEEF, 32'h0, 0, 2'd0, 5'd8, 1);
    step();
    set_id(1, 5'd9, 32'h9999, 5'd10, 32'hAAAA, 32'h1, 1, 2'd3, 5'd11, 0);
    bus.i_stall = 1;
    bus.i_memwb_regwrite = 1; bus.i_memwb_rd = 5'd7; bus.i_memwb_data = 32'h1234_5678;
    step();
    clear_bypass();
    step();
    #1;
    n_vec++; if (bus.o_B !== 32'h1234_5678) begin n_err++; $display("FAIL stall_B got %h want 12345678", bus.o_B); end
    n_vec++; if (bus.o_rt_fwd !== 32'h1234_5678) begin n_err++; $display("FAIL stall_rtfwd got %h want 12345678", bus.o_rt_fwd); end
    n_vec++; if (bus.o_rd_addr !== 5'd8) begin n_err++; $display("FAIL stall_rd got %h want 08", bus.o_rd_addr); end
    n_vec++; if (bus.o_A !== 32'h2) begin n_err++; $display("FAIL stall_A got %h want 00000002", bus.o_A); end
    bus.i_stall = 0;
    step();
    n_vec++; if (bus.o_rd_addr !== 5'd11) begin n_err++; $display("FAIL unstall_rd got %h want 0b", bus.o_rd_addr); end
  endtask

  task automatic test_flush_stall();
    bus.i_stall = 0; bus.i_flush = 0;
    clear_bypass();
    set_id(1, 5'd1, 32'h5, 5'd2, 32'h6, 32'h7, 0, 2'd1, 5'd4, 1);
    step();
    bus.i_stall = 1; bus.i_flush = 1;
    step();
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", bus.o_valid); end
    n_vec++; if (bus.o_regwrite !== 1'b0) begin n_err++; $display("FAIL flush_regwrite got %b want 0", bus.o_regwrite); end
    n_vec++; if (bus.o_A !== 32'h0) begin n_err++; $display("FAIL flush_A got %h want 0", bus.o_A); end
    n_vec++; if (bus.o_rd_addr !== 5'd0) begin n_err++; $display("FAIL flush_rd got %h want 0", bus.o_rd_addr); end
    bus.i_stall = 0; bus.i_flush = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e_a, e_rt, e_b;
    for (int i = 0; i < 300; i++) begin
      set_id(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
             $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      bus.i_stall = ($urandom_range(0, 3) == 0);
      bus.i_flush = ($urandom_range(0, 9) == 0);
      bus.i_exmem_regwrite = 1'($urandom_range(0, 1)); bus.i_exmem_rd = 5'($urandom_range(0, 3)); bus.i_exmem_data = $urandom;
      bus.i_memwb_regwrite = 1'($urandom_range(0, 1)); bus.i_memwb_rd = 5'($urandom_range(0, 3)); bus.i_memwb_data = $urandom;
      step();
      bus.i_exmem_regwrite = 1'($urandom_range(0, 1)); bus.i_exmem_rd = 5'($urandom_range(0, 3)); bus.i_exmem_data = $urandom;
      bus.i_memwb_regwrite = 1'($urandom_range(0, 1)); bus.i_memwb_rd = 5'($urandom_range(0, 3)); bus.i_memwb_data = $urandom;
      #1;
      e_a  = exp_fwd(m_rs_addr, m_rs_data);
      e_rt = exp_fwd(m_rt_addr, m_rt_data);
      e_b  = m_alusrc ? m_imm : e_rt;
      n_vec++; if (bus.o_valid !== m_valid) begin n_err++; $display("FAIL rnd%0d_valid got %b want %b", i, bus.o_valid, m_valid); end
      n_vec++; if (bus.o_A !== e_a) begin n_err++; $display("FAIL rnd%0d_A got %h want %h", i, bus.o_A, e_a); end
      n_vec++; if (bus.o_B !== e_b) begin n_err++; $display("FAIL rnd%0d_B got %h want %h", i, bus.o_B, e_b); end
      n_vec++; if (bus.o_rt_fwd !== e_rt) begin n_err++; $display("FAIL rnd%0d_rtfwd got %h want %h", i, bus.o_rt_fwd, e_rt); end
      n_vec++; if (bus.o_logcontrl !== m_log) begin n_err++; $display("FAIL rnd%0d_log got %h want %h", i, bus.o_logcontrl, m_log); end
      n_vec++; if (bus.o_rd_addr !== m_rd) begin n_err++; $display("FAIL rnd%0d_rd got %h want %h", i, bus.o_rd_addr, m_rd); end
      n_vec++; if (bus.o_regwrite !== (m_rw & m_valid)) begin n_err++; $display("FAIL rnd%0d_regwrite got %b want %b", i, bus.o_regwrite, m_rw & m_valid); end
    end
    bus.i_stall = 0; bus.i_flush = 0;
    clear_bypass();
  endtask

  task automatic test_async_reset();
    bus.i_stall = 0; bus.i_flush = 0;
    clear_bypass();
    set_id(1, 5'd3, 32'hCAFE_F00D, 5'd4, 32'h4, 32'h0, 0, 2'd2, 5'd6, 1);
    step();
    n_vec++; if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_valid got %b want 1", bus.o_valid); end
    bus.i_stall = 1;
    #2;
    rst_n = 0;
    model_bubble();
    #1;
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b want 0", bus.o_valid); end
    n_vec++; if (bus.o_A !== 32'h0) begin n_err++; $display("FAIL arst_A got %h want 0", bus.o_A); end
    n_vec++; if (bus.o_regwrite !== 1'b0) begin n_err++; $display("FAIL arst_regwrite got %b want 0", bus.o_regwrite); end
    @(negedge clk);
    rst_n = 1;
    step();
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL arst_held_valid got %b want 0", bus.o_valid); end
    bus.i_stall = 0;
    step();
    n_vec++; if (bus.o_A !== 32'hCAFE_F00D) begin n_err++; $display("FAIL arst_reload_A got %h want cafef00d", bus.o_A); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_exmem_priority();
    test_reg0();
    test_stall_retire();
    test_flush_stall();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
